enemy_march_ctrl: RTL and testbench

Sequencer for the invader formation's position in the Space Invaders VGA design. It counts frame ticks, derived from the per-frame `y == 400` compare, and steps the formation's left-edge X coordinate. At each screen edge it reverses direction and drops the formation one row, and it flags `landed` when the formation reaches the player line. It sits between `vga_sync` and `graphic` and drives the `ENEMIGOS_FILA_1_X`-style position inputs.

---
 rtl/enemy_march_ctrl.sv | 155 +++++++++++++++
 tb/tb_enemy_march_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/enemy_march_ctrl.sv
// Invader formation march sequencer: counts frame ticks, steps the formation left/right,
// drops it one row at each screen edge and flags landing. Optional macro: MARCH_SPEEDUP_EN.
module enemy_march_ctrl #(
    parameter int X_MIN       = 16,
    parameter int X_MAX       = 496,
    parameter int STEP_X      = 8,
    parameter int STEP_Y      = 16,
    parameter int Y_START     = 64,
    parameter int Y_LIMIT     = 400,
    parameter int PERIOD_INIT = 32,
    parameter int PERIOD_MIN  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pause,
    input  logic [5:0]  alive_cnt,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        dir,
    output logic        step_pulse,
    output logic        landed
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;
    localparam logic [1:0] S_LANDED = 2'd3;

    localparam logic [11:0] XMIN12 = 12'(X_MIN);
    localparam logic [11:0] XMAX12 = 12'(X_MAX);
    localparam logic [11:0] SX12   = 12'(STEP_X);
    localparam logic [11:0] SY12   = 12'(STEP_Y);
    localparam logic [11:0] YLIM12 = 12'(Y_LIMIT);
    localparam logic [10:0] XMIN11 = 11'(X_MIN);
    localparam logic [10:0] YST11  = 11'(Y_START);
    localparam logic [10:0] SX11   = 11'(STEP_X);
    localparam logic [5:0]  PINIT6 = 6'(PERIOD_INIT);

    logic [1:0]  state_q, state_d;
    logic        ftick_d_q;
    logic        tick_q, tick_d;
    logic [5:0]  frame_cnt_q, frame_cnt_d;
    logic [5:0]  period_q, period_d;
    logic [10:0] pos_x_q, pos_x_d;
    logic [10:0] pos_y_q, pos_y_d;
    logic        dir_q, dir_d;
    logic        step_q, step_d;
    logic        landed_q, landed_d;
    logic [5:0]  period_now;
    logic [11:0] px12, new_y12;
    logic        at_edge;

`ifdef MARCH_SPEEDUP_EN
    localparam logic [5:0] PMIN6 = 6'(PERIOD_MIN);
    // Fewer survivors -> shorter period, clamped to [PERIOD_MIN, PERIOD_INIT].
    always_comb begin
        period_now = (alive_cnt < PINIT6) ? alive_cnt : PINIT6;
        if (period_now < PMIN6) period_now = PMIN6;
    end
`else
    logic alive_unused;
    assign alive_unused = ^alive_cnt;
    assign period_now   = PINIT6;
`endif

    assign tick_d  = frame_tick & ~ftick_d_q;
    assign px12    = {1'b0, pos_x_q};
    assign new_y12 = {1'b0, pos_y_q} + SY12;
    assign at_edge = dir_q ? (px12 + SX12 > XMAX12) : (px12 < XMIN12 + SX12);

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        period_d    = period_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_d       = dir_q;
        landed_d    = landed_q;
        step_d      = 1'b0;
        if (start) begin
            // Restart wins over any tick or step landing in the same cycle.
            state_d     = S_WAIT;
            frame_cnt_d = 6'd0;
            period_d    = period_now;
            pos_x_d     = XMIN11;
            pos_y_d     = YST11;
            dir_d       = 1'b1;
            landed_d    = 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (tick_q && !pause) begin
                        if (frame_cnt_q == period_q - 6'd1) begin
                            frame_cnt_d = 6'd0;
                            period_d    = period_now;
                            state_d     = S_STEP;
                        end else begin
                            frame_cnt_d = frame_cnt_q + 6'd1;
                        end
                    end
                end
                S_STEP: begin
                    step_d  = 1'b1;
                    state_d = S_WAIT;
                    if (at_edge) begin
                        pos_y_d = new_y12[10:0];
                        dir_d   = ~dir_q;
                        if (new_y12 >= YLIM12) begin
                            landed_d = 1'b1;
                            state_d  = S_LANDED;
                        end
                    end else begin
                        pos_x_d = dir_q ? pos_x_q + SX11 : pos_x_q - SX11;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ftick_d_q   <= 1'b0;
            tick_q      <= 1'b0;
            frame_cnt_q <= 6'd0;
            period_q    <= PINIT6;
            pos_x_q     <= XMIN11;
            pos_y_q     <= YST11;
            dir_q       <= 1'b1;
            step_q      <= 1'b0;
            landed_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ftick_d_q   <= frame_tick;
            tick_q      <= tick_d;
            frame_cnt_q <= frame_cnt_d;
            period_q    <= period_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            landed_q    <= landed_d;
        end
    end

    assign pos_x      = pos_x_q;
    assign pos_y      = pos_y_q;
    assign dir        = dir_q;
    assign step_pulse = step_q;
    assign landed     = landed_q;

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// Directed bench for enemy_march_ctrl: a default-period instance plus a one-tick-period
// instance sharing the same stimulus, so long marches stay short.
module tb_enemy_march_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame_tick, start, pause;
    logic [5:0]  alive_cnt;
    logic [10:0] sx, sy, fx, fy;
    logic        sdir, ssp, slnd, fdir, fsp, flnd;
    int          vectors = 0;
    int          errors  = 0;
    int          n_slow  = 0;
    int          n_fast  = 0;

    always #5 clk = ~clk;

    enemy_march_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .pause(pause),
        .alive_cnt(alive_cnt), .pos_x(sx), .pos_y(sy), .dir(sdir), .step_pulse(ssp), .landed(slnd)
    );

    enemy_march_ctrl #(.PERIOD_INIT(1), .PERIOD_MIN(1)) dut_fast (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .pause(pause),
        .alive_cnt(alive_cnt), .pos_x(fx), .pos_y(fy), .dir(fdir), .step_pulse(fsp), .landed(flnd)
    );

    always @(negedge clk) begin
        if (ssp === 1'b1) n_slow++;
        if (fsp === 1'b1) n_fast++;
    end

    task automatic tick();
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; alive_cnt = 6'd63;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        vectors++; if (sx !== 11'd16) begin errors++; $display("FAIL rst_pos_x got %0d want 16", sx); end
        vectors++; if (sy !== 11'd64) begin errors++; $display("FAIL rst_pos_y got %0d want 64", sy); end
        vectors++; if (sdir !== 1'b1) begin errors++; $display("FAIL rst_dir got %b want 1", sdir); end
        vectors++; if (ssp !== 1'b0 || slnd !== 1'b0) begin errors++; $display("FAIL rst_flags got sp=%b ld=%b want 0 0", ssp, slnd); end
        ticks(2);
        vectors++; if (fx !== 11'd16 || n_fast != 0) begin errors++; $display("FAIL idle_hold got x=%0d steps=%0d want 16 0", fx, n_fast); end
    endtask

    task automatic test_fixed_period();
        do_start();
        ticks(31);
        vectors++; if (n_slow != 0) begin errors++; $display("FAIL period_31 got %0d steps want 0", n_slow); end
        tick();
        vectors++; if (n_slow != 1) begin errors++; $display("FAIL period_32 got %0d steps want 1", n_slow); end
        vectors++; if (sx !== 11'd24 || sdir !== 1'b1 || sy !== 11'd64) begin errors++; $display("FAIL first_step got x=%0d y=%0d d=%b want 24 64 1", sx, sy, sdir); end
    endtask

    task automatic test_latency();
        logic [10:0] x0;
        x0 = fx;
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #1;
        vectors++; if (fsp !== 1'b0 || fx !== x0) begin errors++; $display("FAIL lat_early got sp=%b x=%0d want 0 %0d", fsp, fx, x0); end
        @(posedge clk); #1;
        vectors++; if (fsp !== 1'b1 || fx !== x0 + 11'd8) begin errors++; $display("FAIL lat_n3 got sp=%b x=%0d want 1 %0d", fsp, fx, x0 + 11'd8); end
        @(posedge clk); #1;
        vectors++; if (fsp !== 1'b0) begin errors++; $display("FAIL lat_width got sp=%b want 0", fsp); end
    endtask

    task automatic test_right_edge();
        do_start();
        ticks(60);
        vectors++; if (fx !== 11'd496 || fdir !== 1'b1 || fy !== 11'd64) begin errors++; $display("FAIL edge_reach got x=%0d y=%0d d=%b want 496 64 1", fx, fy, fdir); end
        tick();
        vectors++; if (fx !== 11'd496 || fy !== 11'd80 || fdir !== 1'b0) begin errors++; $display("FAIL edge_turn got x=%0d y=%0d d=%b want 496 80 0", fx, fy, fdir); end
        tick();
        vectors++; if (fx !== 11'd488) begin errors++; $display("FAIL edge_back got x=%0d want 488", fx); end
    endtask

    task automatic test_landing();
        int n;
        ticks(1218);
        vectors++; if (fy !== 11'd384 || fx !== 11'd496 || flnd !== 1'b0 || fdir !== 1'b1) begin errors++; $display("FAIL pre_land got x=%0d y=%0d d=%b l=%b want 496 384 1 0", fx, fy, fdir, flnd); end
        tick();
        vectors++; if (fy !== 11'd400 || flnd !== 1'b1 || fx !== 11'd496) begin errors++; $display("FAIL land got x=%0d y=%0d l=%b want 496 400 1", fx, fy, flnd); end
        n = n_fast;
        ticks(3);
        vectors++; if (n_fast != n || fy !== 11'd400 || fx !== 11'd496 || flnd !== 1'b1) begin errors++; $display("FAIL land_frozen got steps=%0d y=%0d want %0d 400", n_fast, fy, n); end
        do_start();
        #1;
        vectors++; if (fx !== 11'd16 || fy !== 11'd64 || flnd !== 1'b0 || fdir !== 1'b1) begin errors++; $display("FAIL restart got x=%0d y=%0d l=%b d=%b want 16 64 0 1", fx, fy, flnd, fdir); end
    endtask

    task automatic test_pause();
        int ns, nf;
        do_start();
        ns = n_slow;
        ticks(10);
        nf = n_fast;
        pause = 1'b1;
        ticks(40);
        vectors++; if (n_slow != ns || n_fast != nf) begin errors++; $display("FAIL pause_hold got %0d/%0d steps want %0d/%0d", n_slow, n_fast, ns, nf); end
        pause = 1'b0;
        ticks(21);
        vectors++; if (n_slow != ns) begin errors++; $display("FAIL pause_cnt31 got %0d steps want %0d", n_slow, ns); end
        tick();
        vectors++; if (n_slow != ns + 1 || sx !== 11'd24) begin errors++; $display("FAIL pause_cnt32 got %0d x=%0d want %0d 24", n_slow, sx, ns + 1); end
    endtask

    task automatic test_long_tick();
        int ns, nf;
        do_start();
        ns = n_slow;
        ticks(31);
        nf = n_fast;
        @(posedge clk); #1 frame_tick = 1'b1;
        repeat (1000) @(posedge clk);
        #1 frame_tick = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (n_slow != ns + 1) begin errors++; $display("FAIL long_tick_slow got %0d steps want %0d", n_slow, ns + 1); end
        vectors++; if (n_fast != nf + 1) begin errors++; $display("FAIL long_tick_fast got %0d steps want %0d", n_fast, nf + 1); end
    endtask

    task automatic test_speedup();
        int ns;
`ifdef MARCH_SPEEDUP_EN
        alive_cnt = 6'd5;
        do_start();
        ns = n_slow;
        ticks(4);
        vectors++; if (n_slow != ns) begin errors++; $display("FAIL spd5_early got %0d want %0d", n_slow, ns); end
        tick();
        vectors++; if (n_slow != ns + 1) begin errors++; $display("FAIL spd5 got %0d want %0d", n_slow, ns + 1); end
        alive_cnt = 6'd0;
        ticks(4);
        vectors++; if (n_slow != ns + 1) begin errors++; $display("FAIL spd_next_only got %0d want %0d", n_slow, ns + 1); end
        tick();
        vectors++; if (n_slow != ns + 2) begin errors++; $display("FAIL spd5_second got %0d want %0d", n_slow, ns + 2); end
        tick();
        vectors++; if (n_slow != ns + 2) begin errors++; $display("FAIL spd0_early got %0d want %0d", n_slow, ns + 2); end
        tick();
        vectors++; if (n_slow != ns + 3) begin errors++; $display("FAIL spd0 got %0d want %0d", n_slow, ns + 3); end
        alive_cnt = 6'd50;
        ticks(2);
        vectors++; if (n_slow != ns + 4) begin errors++; $display("FAIL spd0_again got %0d want %0d", n_slow, ns + 4); end
        ticks(31);
        vectors++; if (n_slow != ns + 4) begin errors++; $display("FAIL spd50_early got %0d want %0d", n_slow, ns + 4); end
        tick();
        vectors++; if (n_slow != ns + 5) begin errors++; $display("FAIL spd50 got %0d want %0d", n_slow, ns + 5); end
`else
        alive_cnt = 6'd5;
        do_start();
        ns = n_slow;
        ticks(5);
        vectors++; if (n_slow != ns) begin errors++; $display("FAIL alive_ignored got %0d want %0d", n_slow, ns); end
        ticks(27);
        vectors++; if (n_slow != ns + 1) begin errors++; $display("FAIL alive_ignored32 got %0d want %0d", n_slow, ns + 1); end
`endif
        alive_cnt = 6'd63;
    endtask

    task automatic test_async_reset();
        int nf;
        do_start();
        ticks(63);
        vectors++; if (sx !== 11'd24) begin errors++; $display("FAIL pre_reset_x got %0d want 24", sx); end
        @(posedge clk); #1 frame_tick = 1'b1;
        @(posedge clk); #1 frame_tick = 1'b0;
        @(posedge clk); #3 reset = 1'b0;
        #1;
        vectors++; if (sx !== 11'd16 || ssp !== 1'b0 || sy !== 11'd64) begin errors++; $display("FAIL async_slow got x=%0d y=%0d sp=%b want 16 64 0", sx, sy, ssp); end
        vectors++; if (fx !== 11'd16 || fy !== 11'd64 || fsp !== 1'b0 || fdir !== 1'b1) begin errors++; $display("FAIL async_fast got x=%0d y=%0d sp=%b d=%b want 16 64 0 1", fx, fy, fsp, fdir); end
        @(posedge clk); #1;
        vectors++; if (sx !== 11'd16 || ssp !== 1'b0) begin errors++; $display("FAIL async_held got x=%0d sp=%b want 16 0", sx, ssp); end
        reset = 1'b1;
        nf = n_fast;
        ticks(2);
        vectors++; if (n_fast != nf || fx !== 11'd16) begin errors++; $display("FAIL async_idle got steps=%0d x=%0d want %0d 16", n_fast, fx, nf); end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fixed_period();
        test_latency();
        test_right_edge();
        test_landing();
        test_pause();
        test_long_tick();
        test_speedup();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
